axi4lite_xbar_1xn: RTL and testbench

Parametrised successor to the 1-to-N AXI4-Lite address decoder. It routes one AXI4-Lite manager to NUM_SLAVES subordinates with generic data width, full BRESP/RRESP forwarding and explicit write/read transaction FSMs. Each direction allows one outstanding transaction. An internal decode-error responder completes accesses to unmapped addresses. It sits between the CPU bus bridge and the peripheral subordinates.

---
 rtl/axi4lite_xbar_1xn.sv | 195 +++++++++++++++++++
 tb/tb_axi4lite_xbar_1xn.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_xbar_1xn.sv
// 1-to-N AXI4-Lite crossbar: one manager, NUM_SLAVES subordinates, one outstanding
// transaction per direction, with an internal DECERR responder for unmapped addresses.
module axi4lite_xbar_1xn #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_BASES = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASKS = {NUM_SLAVES{32'hF000_0000}},
    localparam int STRB_W = DATA_WIDTH/8,
    localparam int SEL_W  = $clog2(NUM_SLAVES+1)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             m_awvalid,
    output logic                             m_awready,
    input  logic [ADDR_WIDTH-1:0]            m_awaddr,
    input  logic [2:0]                       m_awprot,
    input  logic                             m_wvalid,
    output logic                             m_wready,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic [STRB_W-1:0]                m_wstrb,
    output logic                             m_bvalid,
    input  logic                             m_bready,
    output logic [1:0]                       m_bresp,
    input  logic                             m_arvalid,
    output logic                             m_arready,
    input  logic [ADDR_WIDTH-1:0]            m_araddr,
    input  logic [2:0]                       m_arprot,
    output logic                             m_rvalid,
    input  logic                             m_rready,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic [1:0]                       m_rresp,
    output logic [NUM_SLAVES-1:0]            s_awvalid,
    input  logic [NUM_SLAVES-1:0]            s_awready,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_awaddr,
    output logic [NUM_SLAVES*3-1:0]          s_awprot,
    output logic [NUM_SLAVES-1:0]            s_wvalid,
    input  logic [NUM_SLAVES-1:0]            s_wready,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wdata,
    output logic [NUM_SLAVES*STRB_W-1:0]     s_wstrb,
    input  logic [NUM_SLAVES-1:0]            s_bvalid,
    output logic [NUM_SLAVES-1:0]            s_bready,
    input  logic [NUM_SLAVES*2-1:0]          s_bresp,
    output logic [NUM_SLAVES-1:0]            s_arvalid,
    input  logic [NUM_SLAVES-1:0]            s_arready,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_araddr,
    output logic [NUM_SLAVES*3-1:0]          s_arprot,
    input  logic [NUM_SLAVES-1:0]            s_rvalid,
    output logic [NUM_SLAVES-1:0]            s_rready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES*2-1:0]          s_rresp
);

    localparam logic [SEL_W-1:0] DEC = SEL_W'(NUM_SLAVES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    wstate_t          w_q, w_d;
    rstate_t          r_q, r_d;
    logic [SEL_W-1:0] wsel_q, wsel_d, rsel_q, rsel_d;
    logic [SEL_W-1:0] sel_aw, sel_ar;

    // Descending scan so the lowest matching index is the one left standing.
    function automatic logic [SEL_W-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [SEL_W-1:0] sel;
        sel = DEC;
        for (int i = NUM_SLAVES-1; i >= 0; i--) begin
            if ((addr & SLAVE_ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLAVE_ADDR_BASES[i*ADDR_WIDTH +: ADDR_WIDTH] &
                 SLAVE_ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]))
                sel = SEL_W'(i);
        end
        return sel;
    endfunction

    assign sel_aw = decode(m_awaddr);
    assign sel_ar = decode(m_araddr);

    assign s_awaddr = {NUM_SLAVES{m_awaddr}};
    assign s_awprot = {NUM_SLAVES{m_awprot}};
    assign s_wdata  = {NUM_SLAVES{m_wdata}};
    assign s_wstrb  = {NUM_SLAVES{m_wstrb}};
    assign s_araddr = {NUM_SLAVES{m_araddr}};
    assign s_arprot = {NUM_SLAVES{m_arprot}};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_q    <= W_IDLE;
            r_q    <= R_IDLE;
            wsel_q <= '0;
            rsel_q <= '0;
        end else begin
            w_q    <= w_d;
            r_q    <= r_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
        end
    end

    always_comb begin
        w_d       = w_q;
        wsel_d    = wsel_q;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        unique case (w_q)
            W_IDLE: begin
                if (sel_aw == DEC) m_awready = 1'b1;
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (sel_aw == SEL_W'(i)) begin
                        s_awvalid[i] = m_awvalid;
                        m_awready    = s_awready[i];
                    end
                end
                if (m_awvalid && m_awready) begin
                    wsel_d = sel_aw;
                    w_d    = W_DATA;
                end
            end
            W_DATA: begin
                if (wsel_q == DEC) m_wready = 1'b1;
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (wsel_q == SEL_W'(i)) begin
                        s_wvalid[i] = m_wvalid;
                        m_wready    = s_wready[i];
                    end
                end
                if (m_wvalid && m_wready) w_d = W_RESP;
            end
            W_RESP: begin
                if (wsel_q == DEC) begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b11;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (wsel_q == SEL_W'(i)) begin
                        m_bvalid    = s_bvalid[i];
                        m_bresp     = s_bresp[i*2 +: 2];
                        s_bready[i] = m_bready;
                    end
                end
                if (m_bvalid && m_bready) w_d = W_IDLE;
            end
            default: w_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_d       = r_q;
        rsel_d    = rsel_q;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        unique case (r_q)
            R_IDLE: begin
                if (sel_ar == DEC) m_arready = 1'b1;
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (sel_ar == SEL_W'(i)) begin
                        s_arvalid[i] = m_arvalid;
                        m_arready    = s_arready[i];
                    end
                end
                if (m_arvalid && m_arready) begin
                    rsel_d = sel_ar;
                    r_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (rsel_q == DEC) begin
                    m_rvalid = 1'b1;
                    m_rresp  = 2'b11;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (rsel_q == SEL_W'(i)) begin
                        m_rvalid    = s_rvalid[i];
                        m_rdata     = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                        m_rresp     = s_rresp[i*2 +: 2];
                        s_rready[i] = m_rready;
                    end
                end
                if (m_rvalid && m_rready) r_d = R_IDLE;
            end
            default: r_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_xbar_1xn.sv
// Bench for axi4lite_xbar_1xn: directed and randomized transactions against
// a reference where slave i owns address region i<<28 and everything else is DECERR.
module tb_axi4lite_xbar_1xn;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW/8;

    logic clk, resetn;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic [N-1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_awaddr, s_araddr;
    logic [N*3-1:0]  s_awprot, s_arprot;
    logic [N*DW-1:0] s_wdata, s_rdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N*2-1:0]  s_bresp, s_rresp;

    int n_assert = 0;
    int n_fail   = 0;

    axi4lite_xbar_1xn #(
        .NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SLAVE_ADDR_BASES({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_ADDR_MASKS({N{32'hF000_0000}})
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: top nibble selects the slave; region >= N is unmapped.
    function automatic int tgt(input logic [31:0] a);
        return (int'(a[31:28]) < N) ? int'(a[31:28]) : N;
    endfunction

    function automatic logic [N-1:0] onehot(input int t);
        logic [N-1:0] v;
        v = '0;
        if (t < N) v[t] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_svalid"}, {s_awvalid, s_wvalid, s_arvalid}, '0);
        chk({tag, "_sready"}, {s_bready, s_rready}, '0);
        chk({tag, "_mvalid"}, {m_bvalid, m_rvalid}, '0);
        chk({tag, "_mresp"},  {m_bresp, m_rresp, m_rdata}, '0);
    endtask

    task automatic clear_inputs();
        m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
        m_awaddr = '0; m_araddr = '0; m_awprot = '0; m_arprot = '0;
        m_wdata = '0; m_wstrb = '0;
        s_awready = '0; s_wready = '0; s_bvalid = '0; s_arready = '0; s_rvalid = '0;
        s_bresp = '0; s_rresp = '0; s_rdata = '0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] bresp,
                            input int lat, input int wpre);
        int t, last;
        logic dec;
        logic [N-1:0] oh;
        t = tgt(addr); dec = (t == N); oh = onehot(t);
        last = dec ? 0 : lat;
        m_wdata = data; m_wstrb = strb;
        for (int c = 0; c < wpre; c++) begin
            m_wvalid = 1; s_wready = '1;
            #1;
            chk("w_before_aw", {m_wready, s_wvalid}, '0);
            step();
        end
        m_awvalid = 1; m_awaddr = addr; m_awprot = 3'($urandom); m_wvalid = (wpre > 0);
        for (int c = 0; c <= last; c++) begin
            s_awready = (N'($urandom) & ~oh) | ((c == last) ? oh : '0);
            s_wready = '1;
            #1;
            chk("aw_valid", s_awvalid, oh);
            chk("aw_ready", m_awready, dec ? 1'b1 : (c == last));
            chk("aw_bcast", {s_awaddr, s_awprot}, {{N{addr}}, {N{m_awprot}}});
            chk("w_held", {m_wready, s_wvalid}, '0);
            step();
        end
        m_awvalid = 0; s_awready = '1; m_wvalid = 1;
        m_awaddr = 32'hFFFF_FFFF;
        for (int c = 0; c <= last; c++) begin
            s_wready = (N'($urandom) & ~oh) | ((c == last) ? oh : '0);
            #1;
            chk("w_valid", s_wvalid, oh);
            chk("w_ready", m_wready, dec ? 1'b1 : (c == last));
            chk("w_bcast", {s_wdata, s_wstrb}, {{N{data}}, {N{strb}}});
            chk("aw_blocked", m_awready, 1'b0);
            step();
        end
        m_wvalid = 0; s_wready = '1; s_awready = '0;
        for (int c = 0; c <= last + 1; c++) begin
            s_bvalid = (N'($urandom) & ~oh) | ((c >= 1) ? oh : '0);
            for (int i = 0; i < N; i++) s_bresp[i*2 +: 2] = (i == t) ? bresp : 2'($urandom);
            m_bready = (c == last + 1);
            #1;
            chk("b_valid", m_bvalid, dec ? 1'b1 : (c >= 1));
            chk("b_resp", m_bresp, dec ? 2'b11 : bresp);
            chk("b_sready", s_bready, (dec || c != last + 1) ? '0 : oh);
            chk("w_ready_resp", m_wready, 1'b0);
            step();
        end
        m_bready = 0; s_bvalid = oh; s_wready = '0;
        #1;
        chk("b_late", {m_bvalid, s_bready}, '0);
        s_bvalid = '0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [1:0] rresp, input int alat, input int rlat);
        int t, alast, rlast;
        logic dec;
        logic [N-1:0] oh;
        t = tgt(addr); dec = (t == N); oh = onehot(t);
        alast = dec ? 0 : alat;
        rlast = dec ? 0 : rlat;
        m_arvalid = 1; m_araddr = addr; m_arprot = 3'($urandom);
        for (int c = 0; c <= alast; c++) begin
            s_arready = (N'($urandom) & ~oh) | ((c == alast) ? oh : '0);
            #1;
            chk("ar_valid", s_arvalid, oh);
            chk("ar_ready", m_arready, dec ? 1'b1 : (c == alast));
            chk("ar_bcast", {s_araddr, s_arprot}, {{N{addr}}, {N{m_arprot}}});
            step();
        end
        m_arvalid = 0; s_arready = '1; m_araddr = 32'h0000_0000;
        for (int c = 0; c <= rlast; c++) begin
            s_rvalid = (N'($urandom) & ~oh) | ((c == rlast) ? oh : '0);
            for (int i = 0; i < N; i++) begin
                s_rdata[i*DW +: DW] = (i == t) ? rdata : $urandom;
                s_rresp[i*2 +: 2]   = (i == t) ? rresp : 2'($urandom);
            end
            m_rready = (c == rlast);
            #1;
            chk("r_valid", m_rvalid, dec ? 1'b1 : (c == rlast));
            chk("r_data", m_rdata, dec ? 32'h0 : rdata);
            chk("r_resp", m_rresp, dec ? 2'b11 : rresp);
            chk("r_sready", s_rready, (dec || c != rlast) ? '0 : oh);
            chk("ar_blocked", {m_arready, s_arvalid}, '0);
            step();
        end
        m_rready = 0; s_rvalid = oh; s_arready = '0;
        #1;
        chk("r_late", {m_rvalid, s_rready}, '0);
        s_rvalid = '0;
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        #12;
        chk_quiet("reset");
        chk("reset_mready", {m_awready, m_wready, m_arready}, '0);
        @(negedge clk);
        resetn = 1;
        step();

        // Directed cases
        do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 1, 0);
        do_read(32'h2000_0010, 32'h1234_5678, 2'b00, 0, 3);
        do_write(32'hF000_0000, 32'h5555_AAAA, 4'h3, 2'b00, 2, 0);
        do_read(32'hF000_0000, 32'h9999_9999, 2'b00, 2, 2);
        do_write(32'h0000_0020, 32'h0BAD_F00D, 4'hC, 2'b10, 0, 2);

        // Concurrent write to slave 0 and read from slave 1, responses back-pressured
        m_awvalid = 1; m_awaddr = 32'h0000_0008; m_arvalid = 1; m_araddr = 32'h1000_000C;
        s_awready = '1; s_arready = '1; s_wready = '1;
        #1;
        chk("cc_aw", {s_awvalid, m_awready}, {4'b0001, 1'b1});
        chk("cc_ar", {s_arvalid, m_arready}, {4'b0010, 1'b1});
        step();
        m_awvalid = 0; m_arvalid = 0; m_awaddr = 32'h2000_0000; m_araddr = 32'h3000_0000;
        m_wvalid = 1; m_wdata = 32'h0102_0304; m_wstrb = 4'hF;
        #1;
        chk("cc_w", {s_wvalid, m_wready}, {4'b0001, 1'b1});
        step();
        m_wvalid = 0; s_bvalid = 4'b0001; s_bresp = 8'b11_10_00_01;
        s_rvalid = 4'b0010; s_rresp = 8'b00_01_10_11;
        s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_1111};
        m_awvalid = 1; m_awaddr = 32'h2000_0004; m_bready = 0; m_rready = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("cc_b_hold", {m_bvalid, m_bresp, s_bready}, {1'b1, 2'b01, 4'b0000});
            chk("cc_r_hold", {m_rvalid, m_rdata, m_rresp, s_rready}, {1'b1, 32'hCAFE_F00D, 2'b10, 4'b0000});
            chk("cc_aw_block", {m_awready, s_awvalid}, '0);
            step();
        end
        m_bready = 1; m_rready = 1;
        #1;
        chk("cc_hs", {s_bready, s_rready, m_awready}, {4'b0001, 4'b0010, 1'b0});
        step();
        m_bready = 0; m_rready = 0; s_bvalid = '0; s_rvalid = '0;
        #1;
        chk("cc_aw2", {s_awvalid, m_awready, m_rvalid}, {4'b0100, 1'b1, 1'b0});
        step();
        m_awvalid = 0; m_wvalid = 1;
        #1;
        chk("cc_w2", s_wvalid, 4'b0100);
        step();
        m_wvalid = 0; s_bvalid = 4'b0100; s_bresp = 8'b00_00_11_11; m_bready = 1;
        #1;
        chk("cc_b2", {m_bvalid, m_bresp, s_bready}, {1'b1, 2'b00, 4'b0100});
        step();
        clear_inputs();

        // Reset in W_RESP with slave 0 still asserting bvalid
        m_awvalid = 1; m_awaddr = 32'h0000_0100; s_awready = '1;
        step();
        m_awvalid = 0; s_awready = '0; m_wvalid = 1; s_wready = '1;
        step();
        m_wvalid = 0; s_wready = '0; s_bvalid = 4'b0001; s_bresp = 8'b00_00_00_10;
        #1;
        chk("rst_pre", {m_bvalid, m_bresp}, {1'b1, 2'b10});
        resetn = 0;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_mready", {m_awready, m_wready, m_arready}, '0);
        step();
        step();
        resetn = 1;
        #1;
        chk("rst_late_b", {m_bvalid, s_bready, m_bresp}, '0);
        s_bvalid = '0;
        step();
        do_write(32'h3000_0040, 32'hA5A5_5A5A, 4'hF, 2'b00, 1, 0);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            a = {4'($urandom_range(0, 6)), 28'($urandom)};
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), 2'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom, 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
